mole_spawner: RTL and testbench

//  Consumes the 8-bit random byte from the random8 generator and turns it into game events.

---
 rtl/mole_spawner_if.sv | 26 ++
 rtl/mole_spawner.sv | 176 +++++++++++++++++
 tb/tb_mole_spawner.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_spawner_if.sv
// rtl/mole_spawner_if.sv - game-side signal bundle between random8/board I/O and mole_spawner
interface mole_spawner_if #(
    parameter int NUM_HOLES = 9
) ();
    logic                 enable;
    logic [7:0]           rand_data;
    logic                 hit;
    logic [3:0]           hit_hole;
    logic                 mole_valid;
    logic [3:0]           mole_hole;
    logic [NUM_HOLES-1:0] mole_onehot;
    logic                 hit_ok;
    logic                 miss;
    logic [7:0]           hits_count;
    logic [7:0]           miss_count;

    modport master (
        output enable, rand_data, hit, hit_hole,
        input  mole_valid, mole_hole, mole_onehot, hit_ok, miss, hits_count, miss_count
    );

    modport slave (
        input  enable, rand_data, hit, hit_hole,
        output mole_valid, mole_hole, mole_onehot, hit_ok, miss, hits_count, miss_count
    );
endinterface

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - picks mole holes from random bytes, times up-time, judges hits and tallies
// Optional MOLE_WRONG_HIT_PENALTY_EN: a wrong-hole hit while a mole is up counts as a miss.
module mole_spawner #(
    parameter int NUM_HOLES = 9,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_BASE  = 200,
    parameter int UP_BASE   = 400,
    parameter int MAX_TRIES = 16
) (
    input  logic          clock,
    input  logic          reset,
    mole_spawner_if.slave bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, GAP, PICK, UP} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [11:0]          gap_q, gap_d;
    logic [11:0]          up_q, up_d;
    logic [7:0]           try_q, try_d;
    logic [3:0]           hole_q, hole_d;
    logic                 last_valid_q, last_valid_d;
    logic [7:0]           hits_q, hits_d;
    logic [7:0]           miss_cnt_q, miss_cnt_d;
    logic                 hit_ok_q, hit_ok_d;
    logic                 miss_q, miss_d;
    logic                 valid_q;
    logic [NUM_HOLES-1:0] onehot_q, onehot_d;

    logic        tick, accept, correct, wrong, timeout;
    logic [3:0]  h, forced_h;
    logic [11:0] new_gap;

    assign tick     = (state_q != IDLE) && (div_q == DIV_W'(TICK_DIV - 1));
    assign h        = bus.rand_data[3:0];
    assign accept   = ({1'b0, h} < 5'(NUM_HOLES)) && !(last_valid_q && (h == hole_q));
    assign forced_h = !last_valid_q                   ? 4'd0 :
                      (hole_q == 4'(NUM_HOLES - 1))   ? 4'd0 : hole_q + 4'd1;
    assign new_gap  = 12'(GAP_BASE) + {4'd0, bus.rand_data};
    // hole_q is always < NUM_HOLES, so an out-of-range hit_hole can never match
    assign correct  = bus.hit && (bus.hit_hole == hole_q);
    assign timeout  = tick && (up_q == 12'd0);
`ifdef MOLE_WRONG_HIT_PENALTY_EN
    assign wrong    = bus.hit && (bus.hit_hole != hole_q);
`else
    assign wrong    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        div_d        = '0;
        gap_d        = gap_q;
        up_d         = up_q;
        try_d        = try_q;
        hole_d       = hole_q;
        last_valid_d = last_valid_q;
        hits_d       = hits_q;
        miss_cnt_d   = miss_cnt_q;
        hit_ok_d     = 1'b0;
        miss_d       = 1'b0;
        if ((state_q != IDLE) && !tick) begin
            div_d = div_q + DIV_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    gap_d   = new_gap;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == 12'd0) begin
                        state_d = PICK;
                    end else begin
                        gap_d = gap_q - 12'd1;
                    end
                end
            end
            PICK: begin
                if (accept) begin
                    hole_d  = h;
                    up_d    = 12'(UP_BASE) + {4'd0, bus.rand_data[7:4], 4'd0};
                    try_d   = '0;
                    state_d = UP;
                end else if (try_q == 8'(MAX_TRIES - 1)) begin
                    hole_d  = forced_h;
                    up_d    = 12'(UP_BASE);
                    try_d   = '0;
                    state_d = UP;
                end else begin
                    try_d = try_q + 8'd1;
                end
            end
            default: begin
                last_valid_d = 1'b1;
                if (correct) begin
                    hit_ok_d = 1'b1;
                    if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                    gap_d    = new_gap;
                    state_d  = GAP;
                end else begin
                    if (timeout) begin
                        gap_d   = new_gap;
                        state_d = GAP;
                    end else if (tick) begin
                        up_d = up_q - 12'd1;
                    end
                    // a wrong hit coinciding with timeout is still a single miss
                    if (timeout || wrong) begin
                        miss_d = 1'b1;
                        if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                end
            end
        endcase
        if (!bus.enable) begin
            state_d    = IDLE;
            try_d      = '0;
            hole_d     = hole_q;
            hits_d     = hits_q;
            miss_cnt_d = miss_cnt_q;
            hit_ok_d   = 1'b0;
            miss_d     = 1'b0;
        end
    end

    always_comb begin
        onehot_d = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            onehot_d[i] = (state_d == UP) && (hole_d == 4'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            gap_q        <= '0;
            up_q         <= '0;
            try_q        <= '0;
            hole_q       <= '0;
            last_valid_q <= 1'b0;
            hits_q       <= '0;
            miss_cnt_q   <= '0;
            hit_ok_q     <= 1'b0;
            miss_q       <= 1'b0;
            valid_q      <= 1'b0;
            onehot_q     <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            gap_q        <= gap_d;
            up_q         <= up_d;
            try_q        <= try_d;
            hole_q       <= hole_d;
            last_valid_q <= last_valid_d;
            hits_q       <= hits_d;
            miss_cnt_q   <= miss_cnt_d;
            hit_ok_q     <= hit_ok_d;
            miss_q       <= miss_d;
            valid_q      <= (state_d == UP);
            onehot_q     <= onehot_d;
        end
    end

    assign bus.mole_valid  = valid_q;
    assign bus.mole_hole   = hole_q;
    assign bus.mole_onehot = onehot_q;
    assign bus.hit_ok      = hit_ok_q;
    assign bus.miss        = miss_q;
    assign bus.hits_count  = hits_q;
    assign bus.miss_count  = miss_cnt_q;
endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - scoreboard bench for mole_spawner against a tick-deadline game model
module tb_mole_spawner;
    localparam int N  = 9;
    localparam int TD = 4;
    localparam int GB = 2;
    localparam int UB = 3;
    localparam int MT = 16;

    localparam int EV_APPEAR = 0;
    localparam int EV_VANISH = 1;
    localparam int EV_HIT    = 2;
    localparam int EV_MISS   = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mole_spawner_if #(.NUM_HOLES(N)) bus ();

    mole_spawner #(
        .NUM_HOLES(N), .TICK_DIV(TD), .GAP_BASE(GB), .UP_BASE(UB), .MAX_TRIES(MT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Game model: phases with absolute tick deadlines counted from leaving idle.
    int m_mode = 0;   // 0 idle, 1 gap, 2 pick, 3 up
    int m_c = 0, m_ticks = 0, m_end = 0, m_tries = 0;
    int m_hole = 0, m_hits = 0, m_miss = 0;
    bit m_lv = 0;

    function automatic void push(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    always @(posedge clock) begin : model
        bit tick, ok, correct, timeout, wrong;
        int h, g;
        g = GB + int'(bus.rand_data);
        if (reset) begin
            if (m_mode == 3) push(EV_VANISH, 0);
            m_mode = 0; m_hole = 0; m_lv = 0; m_hits = 0; m_miss = 0; m_tries = 0;
        end else if (!bus.enable) begin
            if (m_mode == 3) push(EV_VANISH, 0);
            m_mode = 0; m_tries = 0;
        end else begin
            tick = (m_mode != 0) && (m_c % TD == TD - 1);
            if (m_mode != 0) m_c++;
            if (tick) m_ticks++;
            case (m_mode)
                0: begin
                    m_c = 0; m_ticks = 0; m_end = g + 1; m_mode = 1;
                end
                1: if (tick && m_ticks == m_end) m_mode = 2;
                2: begin
                    h  = int'(bus.rand_data[3:0]);
                    ok = (h < N) && !(m_lv && h == m_hole);
                    m_tries++;
                    if (ok || m_tries == MT) begin
                        m_hole  = ok ? h : (m_lv ? (m_hole + 1) % N : 0);
                        m_end   = m_ticks + 1 + (ok ? UB + 16 * int'(bus.rand_data[7:4]) : UB);
                        m_tries = 0; m_lv = 1; m_mode = 3;
                        push(EV_APPEAR, m_hole);
                    end
                end
                default: begin
                    correct = bus.hit && (int'(bus.hit_hole) == m_hole);
                    timeout = tick && (m_ticks == m_end);
`ifdef MOLE_WRONG_HIT_PENALTY_EN
                    wrong = bus.hit && !correct;
`else
                    wrong = 1'b0;
`endif
                    if (correct) begin
                        if (m_hits < 255) m_hits++;
                        push(EV_HIT, m_hits);
                        push(EV_VANISH, 0);
                        m_end = m_ticks + g + 1; m_mode = 1;
                    end else begin
                        if (timeout || wrong) begin
                            if (m_miss < 255) m_miss++;
                            push(EV_MISS, m_miss);
                        end
                        if (timeout) begin
                            push(EV_VANISH, 0);
                            m_end = m_ticks + g + 1; m_mode = 1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic expect_ev(int kind, int act, string name);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event with value %0d, none expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != act) begin
                n_bad++;
                $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d",
                         name, kind, act, e.kind, e.val);
            end
            if (kind == EV_APPEAR && e.kind == EV_APPEAR)
                check("appear_onehot", int'(bus.mole_onehot), 1 << e.val);
        end
    endtask

    bit prev_valid = 1'b0;
    always @(negedge clock) begin : monitor
        if (bus.hit_ok === 1'b1) expect_ev(EV_HIT, int'(bus.hits_count), "hit_ok_event");
        if (bus.miss === 1'b1) expect_ev(EV_MISS, int'(bus.miss_count), "miss_event");
        if (bus.mole_valid === 1'b1 && !prev_valid) expect_ev(EV_APPEAR, int'(bus.mole_hole), "appear_event");
        if (bus.mole_valid !== 1'b1 && prev_valid) expect_ev(EV_VANISH, 0, "vanish_event");
        prev_valid = (bus.mole_valid === 1'b1);
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic bit sig(int which);
        case (which)
            0:       return bus.mole_valid === 1'b1;
            2:       return bus.miss === 1'b1;
            default: return bus.hit_ok === 1'b1;
        endcase
    endfunction

    task automatic wait_for(int which, int budget, string name, output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!sig(which) && waited < budget);
        if (!sig(which)) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no response within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_final_tick(int budget);
        int w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!(m_mode == 3 && (m_c % TD == TD - 1) && (m_ticks + 1 == m_end)) && w < budget);
        if (w >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL final_tick_wait: no final tick within %0d cycles", budget);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_valid"},  int'(bus.mole_valid), 0);
        check({tag, "_hole"},   int'(bus.mole_hole), 0);
        check({tag, "_onehot"}, int'(bus.mole_onehot), 0);
        check({tag, "_hit_ok"}, int'(bus.hit_ok), 0);
        check({tag, "_miss"},   int'(bus.miss), 0);
        check({tag, "_hits"},   int'(bus.hits_count), 0);
        check({tag, "_misses"}, int'(bus.miss_count), 0);
    endtask

    task automatic pulse_hit(int hole);
        bus.hit = 1'b1;
        bus.hit_hole = 4'(hole);
        cyc(1);
        bus.hit = 1'b0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        reset = 1'b1;
        bus.enable = 1'b0; bus.rand_data = 8'h00; bus.hit = 1'b0; bus.hit_hole = 4'd0;
        cyc(3);
        check_zero("reset");

        reset = 1'b0; bus.rand_data = 8'h05; bus.enable = 1'b1;
        wait_for(0, 200, "first_mole", w);
        check("first_mole_latency", w, 34);
        check("first_mole_hole", int'(bus.mole_hole), 5);
        check("first_mole_onehot", int'(bus.mole_onehot), 'h020);
        wait_for(2, 200, "first_timeout", w);
        check("up_time_cycles", w, 15);
        check("first_miss_count", int'(bus.miss_count), 1);

        wait_for(0, 300, "forced_mole", w);
        check("forced_next_hole", int'(bus.mole_hole), 6);
        cyc(1);
        pulse_hit(6);
        check("hit_ok_pulse", int'(bus.hit_ok), 1);
        check("hit_no_miss", int'(bus.miss), 0);
        check("hit_count", int'(bus.hits_count), 1);
        check("hit_mole_down", int'(bus.mole_valid), 0);

        reset = 1'b1; bus.rand_data = 8'h0C;
        cyc(2);
        check_zero("reset2");
        reset = 1'b0;
        wait_for(0, 300, "forced_zero_mole", w);
        check("forced_zero_hole", int'(bus.mole_hole), 0);
        wait_for(2, 300, "zero_timeout", w);
        wait_for(0, 300, "forced_one_mole", w);
        check("forced_wrap_hole", int'(bus.mole_hole), 1);
        bus.enable = 1'b0;
        cyc(1);
        check("disable_valid", int'(bus.mole_valid), 0);
        check("disable_no_miss", int'(bus.miss), 0);
        check("disable_no_hit", int'(bus.hit_ok), 0);
        check("disable_miss_held", int'(bus.miss_count), 1);
        check("disable_hole_held", int'(bus.mole_hole), 1);
        bus.enable = 1'b1;
        cyc(10);
        reset = 1'b1;
        cyc(1);
        check_zero("reset_mid_gap");
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            bus.rand_data = 8'($urandom_range(0, 3));
            wait_for(2, 400, "sat_timeout", w);
        end
        check("miss_saturated", int'(bus.miss_count), 255);
        wait_final_tick(400);
        pulse_hit(m_hole);
        check("final_tick_hit_ok", int'(bus.hit_ok), 1);
        check("final_tick_no_miss", int'(bus.miss), 0);
        check("final_tick_hits", int'(bus.hits_count), 1);
        check("final_tick_miss_held", int'(bus.miss_count), 255);

        reset = 1'b1; bus.rand_data = 8'h05;
        cyc(2);
        reset = 1'b0;
        wait_for(0, 200, "wrong_hit_mole", w);
        cyc(1);
        pulse_hit(2);
`ifdef MOLE_WRONG_HIT_PENALTY_EN
        check("wrong_hit_miss", int'(bus.miss), 1);
        check("wrong_hit_count", int'(bus.miss_count), 1);
`else
        check("wrong_hit_miss", int'(bus.miss), 0);
        check("wrong_hit_count", int'(bus.miss_count), 0);
`endif
        check("wrong_hit_still_up", int'(bus.mole_valid), 1);

        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            bus.rand_data = 8'($urandom) & 8'h3F;
            bus.enable = ($urandom_range(0, 299) != 0);
            if (!bus.hit && $urandom_range(0, 7) == 0) begin
                bus.hit = 1'b1;
                bus.hit_hole = ($urandom_range(0, 1) == 1) ? 4'(m_hole) : 4'($urandom_range(0, 15));
            end else begin
                bus.hit = 1'b0;
            end
        end
        bus.hit = 1'b0;
        bus.enable = 1'b0;
        cyc(3);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_hits", int'(bus.hits_count), m_hits);
        check("final_misses", int'(bus.miss_count), m_miss);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
